// File: rtl/end_sync_pkg.sv
// Shared types and constants for the end-synchronisation block.
package end_sync_pkg;

  localparam int unsigned MAX_NUM_MEMORIES = 32;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_e;

  // A zero-memory build still needs a 1-bit vector to keep the ports legal.
  function automatic int unsigned mem_vec_w(input int unsigned n);
    return (n == 0) ? 1 : n;
  endfunction

endpackage

// File: rtl/end_sync_done_tracker.sv
// Sticky per-memory completion flags with ready generation and an all-done summary.
module end_sync_done_tracker
  import end_sync_pkg::*;
#(
  parameter  int unsigned N = 2,
  localparam int unsigned W = mem_vec_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clear_i,
  input  logic [W-1:0] valid_i,
  output logic [W-1:0] ready_o,
  output logic         all_done_o
);

  // With N = 0 the mask removes the unused filler bit: never ready, always done.
  localparam logic [W-1:0] MASK = (N == 0) ? '0 : '1;

  logic [W-1:0] done_q;
  logic [W-1:0] done_d;
  logic [W-1:0] fire;

  assign ready_o    = en_i ? (~done_q & MASK) : '0;
  assign fire       = valid_i & ready_o;
  assign all_done_o = &(done_q | fire | ~MASK);
  assign done_d     = clear_i ? '0 : (done_q | fire);

  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/end_sync_mem.sv
// Joins one kernel result with NUM_MEMORIES completion tokens into a single end token.
// Optional END_SYNC_MEM_BYPASS_EN: emit in the completing cycle instead of one cycle later.
module end_sync_mem
  import end_sync_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH   = 32,
  parameter  int unsigned NUM_MEMORIES = 2,
  localparam int unsigned NM_W         = mem_vec_w(NUM_MEMORIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic [NM_W-1:0]       mem_done_valid,
  output logic [NM_W-1:0]       mem_done_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  state_e                state_q;
  state_e                state_d;
  logic                  res_got_q;
  logic                  res_got_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  logic collect;
  logic res_fire;
  logic res_now;
  logic all_done;
  logic complete;
  logic clear;

  assign collect   = (state_q == COLLECT);
  assign ins_ready = collect & ~res_got_q;
  assign res_fire  = ins_valid & ins_ready;
  assign res_now   = res_got_q | res_fire;
  // Includes tokens transferring this cycle, so the set can complete in one edge.
  assign complete  = collect & res_now & all_done;

  end_sync_done_tracker #(
    .N (NUM_MEMORIES)
  ) u_done (
    .clk        (clk),
    .rst        (rst),
    .en_i       (collect),
    .clear_i    (clear),
    .valid_i    (mem_done_valid),
    .ready_o    (mem_done_ready),
    .all_done_o (all_done)
  );

  always_comb begin
    state_d    = state_q;
    res_got_d  = res_got_q;
    data_d     = data_q;
    clear      = 1'b0;
    outs_valid = 1'b0;
    outs       = data_q;
    if (res_fire) begin
      data_d = ins;
    end
    case (state_q)
      COLLECT: begin
        res_got_d = res_now;
        if (complete) begin
`ifdef END_SYNC_MEM_BYPASS_EN
          outs_valid = 1'b1;
          outs       = res_fire ? ins : data_q;
          if (outs_ready) begin
            clear     = 1'b1;
            res_got_d = 1'b0;
          end else begin
            state_d = EMIT;
          end
`else
          state_d = EMIT;
`endif
        end
      end
      EMIT: begin
        outs_valid = 1'b1;
        if (outs_ready) begin
          clear     = 1'b1;
          res_got_d = 1'b0;
          state_d   = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= COLLECT;
      res_got_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      res_got_q <= res_got_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_end_sync_mem.sv
// Bench for end_sync_mem: directed scenarios plus randomized traffic against a token-level model.
module tb_end_sync_mem;

`ifdef END_SYNC_MEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic [1:0]  mem_done_valid;
  logic [1:0]  mem_done_ready;
  logic [31:0] outs;
  logic        outs_valid;
  logic        outs_ready;

  logic [31:0] z_ins;
  logic        z_ins_valid;
  logic        z_ins_ready;
  logic [0:0]  z_mem_valid;
  logic [0:0]  z_mem_ready;
  logic [31:0] z_outs;
  logic        z_outs_valid;
  logic        z_outs_ready;

  int checks = 0;
  int errors = 0;

  end_sync_mem #(.DATA_WIDTH(32), .NUM_MEMORIES(2)) dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .mem_done_valid(mem_done_valid), .mem_done_ready(mem_done_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready)
  );

  end_sync_mem #(.DATA_WIDTH(32), .NUM_MEMORIES(0)) dut0 (
    .clk(clk), .rst(rst), .ins(z_ins), .ins_valid(z_ins_valid), .ins_ready(z_ins_ready),
    .mem_done_valid(z_mem_valid), .mem_done_ready(z_mem_ready),
    .outs(z_outs), .outs_valid(z_outs_valid), .outs_ready(z_outs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    ins = '0; ins_valid = 1'b0; mem_done_valid = 2'b00; outs_ready = 1'b0;
    z_ins = '0; z_ins_valid = 1'b0; z_mem_valid = 1'b0; z_outs_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (outs_valid !== 1'b0) begin errors++; $display("FAIL reset_outs_valid got %b want 0", outs_valid); end
    checks++;
    if (dut.data_q !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", dut.data_q); end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ins_ready !== 1'b1) begin errors++; $display("FAIL reset_ins_ready got %b want 1", ins_ready); end
    checks++;
    if (mem_done_ready !== 2'b11) begin errors++; $display("FAIL reset_mem_ready got %b want 11", mem_done_ready); end
    checks++;
    if (z_ins_ready !== 1'b1 || z_outs_valid !== 1'b0) begin
      errors++; $display("FAIL reset_nm0 got ready=%b valid=%b want 1 0", z_ins_ready, z_outs_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_in_order();
    int hs = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      ins = 32'hDEADBEEF;
      ins_valid = (c == 0);
      mem_done_valid = {c == 5, c == 3};
      outs_ready = 1'b1;
      #1;
      checks++;
      if (outs_valid !== (c == (BYP ? 5 : 6))) begin
        errors++; $display("FAIL in_order_valid cycle %0d got %b want %b", c, outs_valid, c == (BYP ? 5 : 6));
      end
      if (outs_valid === 1'b1) begin
        checks++;
        if (outs !== 32'hDEADBEEF) begin errors++; $display("FAIL in_order_data got %h want deadbeef", outs); end
        hs++;
      end
      @(negedge clk);
    end
    checks++;
    if (hs != 1) begin errors++; $display("FAIL in_order_count got %0d want 1", hs); end
  endtask

  task automatic test_hold();
    logic [31:0] r;
    r = $urandom;
    do_reset();
    ins = r; ins_valid = 1'b1; mem_done_valid = 2'b11; outs_ready = 1'b0;
    @(negedge clk);
    idle_inputs();
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++;
      if (outs_valid !== 1'b1 || outs !== r) begin
        errors++; $display("FAIL hold_out cycle %0d got v=%b d=%h want v=1 d=%h", c, outs_valid, outs, r);
      end
      checks++;
      if (ins_ready !== 1'b0 || mem_done_ready !== 2'b00) begin
        errors++; $display("FAIL hold_ready cycle %0d got %b %b want 0 00", c, ins_ready, mem_done_ready);
      end
      @(negedge clk);
    end
    outs_ready = 1'b1;
    #1;
    checks++;
    if (outs_valid !== 1'b1 || outs !== r) begin
      errors++; $display("FAIL hold_release got v=%b d=%h want v=1 d=%h", outs_valid, outs, r);
    end
    @(negedge clk);
    outs_ready = 1'b0;
    #1;
    checks++;
    if (outs_valid !== 1'b0 || ins_ready !== 1'b1 || mem_done_ready !== 2'b11) begin
      errors++; $display("FAIL hold_after got v=%b ir=%b mr=%b want 0 1 11", outs_valid, ins_ready, mem_done_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_sticky();
    int acc = 0;
    int hs = 0;
    logic [31:0] r;
    r = $urandom;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      mem_done_valid = 2'b01;
      #1;
      checks++;
      if (mem_done_ready[0] !== (c == 0)) begin
        errors++; $display("FAIL sticky_ready cycle %0d got %b want %b", c, mem_done_ready[0], c == 0);
      end
      if (mem_done_valid[0] && mem_done_ready[0]) acc++;
      @(negedge clk);
    end
    checks++;
    if (acc != 1) begin errors++; $display("FAIL sticky_count got %0d want 1", acc); end
    for (int c = 5; c < 9; c++) begin
      ins = r; ins_valid = (c == 5); mem_done_valid = (c == 5) ? 2'b10 : 2'b00; outs_ready = 1'b1;
      #1;
      if (outs_valid === 1'b1) begin
        hs++;
        checks++;
        if (outs !== r) begin errors++; $display("FAIL sticky_data got %h want %h", outs, r); end
      end
      @(negedge clk);
    end
    checks++;
    if (hs != 1) begin errors++; $display("FAIL sticky_tokens got %0d want 1", hs); end
    idle_inputs();
  endtask

  task automatic test_reset_emit();
    do_reset();
    ins = $urandom | 32'h1; ins_valid = 1'b1; mem_done_valid = 2'b11; outs_ready = 1'b0;
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (outs_valid !== 1'b0 || ins_ready !== 1'b1 || mem_done_ready !== 2'b11) begin
      errors++; $display("FAIL rst_emit got v=%b ir=%b mr=%b want 0 1 11", outs_valid, ins_ready, mem_done_ready);
    end
    checks++;
    if (dut.data_q !== 32'h0) begin errors++; $display("FAIL rst_emit_data got %h want 0", dut.data_q); end
    outs_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (outs_valid !== 1'b0) begin errors++; $display("FAIL rst_emit_stale cycle %0d got %b want 0", c, outs_valid); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // Token-level reference: results queue in order; an end token needs the result plus every done.
  task automatic test_random();
    logic [31:0] sb[$];
    bit have_res;
    bit [1:0] have_done;
    bit emitting;
    bit e_ir, e_ov, acc_r, comp;
    bit [1:0] e_mr, acc_d;
    do_reset();
    have_res = 0; have_done = 0; emitting = 0;
    for (int c = 0; c < 400; c++) begin
      ins = $urandom;
      ins_valid = ($urandom_range(0, 2) == 0);
      mem_done_valid = 2'($urandom_range(0, 3));
      outs_ready = ($urandom_range(0, 1) == 1);
      #1;
      e_ir = !emitting && !have_res;
      e_mr = emitting ? 2'b00 : ~have_done;
      acc_r = ins_valid && e_ir;
      acc_d = mem_done_valid & e_mr;
      if (acc_r) sb.push_back(ins);
      comp = !emitting && (have_res || acc_r) && ((have_done | acc_d) == 2'b11);
      e_ov = emitting || (BYP && comp);
      checks++;
      if (ins_ready !== e_ir || mem_done_ready !== e_mr) begin
        errors++; $display("FAIL rand_ready cycle %0d got %b %b want %b %b", c, ins_ready, mem_done_ready, e_ir, e_mr);
      end
      checks++;
      if (outs_valid !== e_ov) begin errors++; $display("FAIL rand_valid cycle %0d got %b want %b", c, outs_valid, e_ov); end
      if (e_ov && sb.size() > 0) begin
        checks++;
        if (outs !== sb[0]) begin errors++; $display("FAIL rand_data cycle %0d got %h want %h", c, outs, sb[0]); end
      end
      if (e_ov && outs_ready) begin
        void'(sb.pop_front());
        have_res = 0; have_done = 0; emitting = 0;
      end else if (!emitting) begin
        have_res = have_res || acc_r;
        have_done = have_done | acc_d;
        emitting = comp;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

`ifdef END_SYNC_MEM_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    ins = 32'h5; ins_valid = 1'b1; mem_done_valid = 2'b11; outs_ready = 1'b1;
    #1;
    checks++;
    if (outs_valid !== 1'b1 || outs !== 32'h5) begin
      errors++; $display("FAIL bypass_same_cycle got v=%b d=%h want 1 5", outs_valid, outs);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (dut.state_q !== end_sync_pkg::COLLECT || outs_valid !== 1'b0 || ins_ready !== 1'b1) begin
      errors++; $display("FAIL bypass_after got st=%b v=%b ir=%b want 0 0 1", dut.state_q, outs_valid, ins_ready);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_passthru();
    logic [31:0] vals[3];
    logic [31:0] got[$];
    int slot[$];
    int idx = 0;
    vals[0] = 32'd1; vals[1] = 32'd2; vals[2] = 32'd3;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      z_ins_valid = (idx < 3);
      z_ins = (idx < 3) ? vals[idx] : 32'h0;
      z_outs_ready = 1'b1;
      #1;
      if (z_outs_valid && z_outs_ready) begin got.push_back(z_outs); slot.push_back(c); end
      if (z_ins_valid && z_ins_ready) idx++;
      @(negedge clk);
    end
    checks++;
    if (got.size() != 3) begin
      errors++; $display("FAIL passthru_count got %0d want 3", got.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] !== vals[i]) begin errors++; $display("FAIL passthru_data %0d got %h want %h", i, got[i], vals[i]); end
        checks++;
        if (slot[i] != i * (BYP ? 1 : 2) + (BYP ? 0 : 1)) begin
          errors++; $display("FAIL passthru_timing %0d got %0d want %0d", i, slot[i], i * (BYP ? 1 : 2) + (BYP ? 0 : 1));
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_in_order();
    test_hold();
    test_sticky();
    test_reset_emit();
`ifdef END_SYNC_MEM_BYPASS_EN
    test_bypass();
`endif
    test_passthru();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
